fir3p_input_packer: RTL and testbench

Serial-to-3-parallel sample packer at the input side of the 3-parallel FIR filter. It accepts one NBIT-bit sample per cycle under a valid strobe and groups consecutive samples into triplets x[3k], x[3k+1], x[3k+2]. Each complete triplet is presented as one registered word with a one-cycle valid pulse, matching the filter's Din3k/Din3k1/Din3k2/Vin input interface. A flush request closes a partial group by zero-padding it, so a stream tail is never lost.

---
 rtl/fir3p_input_packer.sv | 52 +++++
 tb/tb_fir3p_input_packer.sv | 114 +++++++++++
 2 files changed

// File: rtl/fir3p_input_packer.sv
// fir3p_input_packer: groups serial samples into zero-padded-on-flush triplets
// for the 3-parallel FIR input interface.
module fir3p_input_packer #(
    parameter int NBIT = 10
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic [NBIT-1:0] DIN,
    input  logic            VIN,
    input  logic            FLUSH,
    output logic [NBIT-1:0] DOUT3k,
    output logic [NBIT-1:0] DOUT3k1,
    output logic [NBIT-1:0] DOUT3k2,
    output logic            VOUT,
    output logic            PAD,
    output logic [1:0]      PHASE
);
    logic [NBIT-1:0] slot0, slot1, s0_n, s1_n;
    logic [1:0] cnt;
    logic full, close;
    // cnt is the group size after this edge's sample; s*_n the slots including it
    always_comb begin
        cnt   = PHASE + {1'b0, VIN};
        full  = cnt == 2'd3;
        close = full || (FLUSH && cnt != 2'd0);
        s0_n  = (VIN && PHASE == 2'd0) ? DIN : slot0;
        s1_n  = (VIN && PHASE == 2'd1) ? DIN : slot1;
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            slot0   <= '0;
            slot1   <= '0;
            DOUT3k  <= '0;
            DOUT3k1 <= '0;
            DOUT3k2 <= '0;
            VOUT    <= 1'b0;
            PAD     <= 1'b0;
            PHASE   <= 2'd0;
        end else begin
            slot0 <= s0_n;
            slot1 <= s1_n;
            VOUT  <= close;
            PAD   <= close && !full;
            PHASE <= close ? 2'd0 : cnt;
            if (close) begin
                DOUT3k  <= s0_n;
                DOUT3k1 <= cnt >= 2'd2 ? s1_n : '0;
                DOUT3k2 <= full ? DIN : '0;
            end
        end
    end
endmodule

// File: tb/tb_fir3p_input_packer.sv
// tb_fir3p_input_packer: directed and random stimulus against a queue-based
// model of sample grouping.
module tb_fir3p_input_packer;
    localparam int NBIT = 10;
    logic CLK = 1'b0, RST_n = 1'b0, VIN = 1'b0, FLUSH = 1'b0;
    logic [NBIT-1:0] DIN = '0;
    logic [NBIT-1:0] DOUT3k, DOUT3k1, DOUT3k2;
    logic VOUT, PAD;
    logic [1:0] PHASE;

    fir3p_input_packer #(.NBIT(NBIT)) dut (
        .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN), .FLUSH(FLUSH),
        .DOUT3k(DOUT3k), .DOUT3k1(DOUT3k1), .DOUT3k2(DOUT3k2),
        .VOUT(VOUT), .PAD(PAD), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0, dut_groups = 0, ref_groups = 0;
    logic [NBIT-1:0] q[$];
    logic [NBIT-1:0] e0 = '0, e1 = '0, e2 = '0;
    logic ev = 1'b0, ep = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("vout", 32'(VOUT), 32'(ev));
        check("pad", 32'(PAD), 32'(ep));
        check("phase", 32'(PHASE), 32'(q.size()));
        check("d3k", 32'(DOUT3k), 32'(e0));
        check("d3k1", 32'(DOUT3k1), 32'(e1));
        check("d3k2", 32'(DOUT3k2), 32'(e2));
    endtask

    // Drive one cycle, advance the model by the grouping rules, compare after the edge
    task automatic step(input logic v, input logic [NBIT-1:0] d, input logic f);
        @(negedge CLK);
        VIN = v; DIN = d; FLUSH = f;
        @(posedge CLK);
        ev = 1'b0; ep = 1'b0;
        if (v) q.push_back(d);
        if (q.size() == 3 || (f && q.size() > 0)) begin
            ev = 1'b1;
            ep = q.size() < 3;
            e0 = q[0];
            e1 = q.size() > 1 ? q[1] : '0;
            e2 = q.size() > 2 ? q[2] : '0;
            q.delete();
            ref_groups++;
        end
        #1;
        if (VOUT) dut_groups++;
        compare_all();
        @(negedge CLK);
        VIN = 1'b0; FLUSH = 1'b0;
    endtask

    initial begin
        #3;
        compare_all();
        @(negedge CLK);
        RST_n = 1'b1;

        for (int i = 1; i <= 6; i++) step(1'b1, NBIT'(i), 1'b0);
        check("grp2_d3k", 32'(DOUT3k), 32'd4);

        step(1'b1, 10'd10, 1'b0); step(1'b0, '0, 1'b0); step(1'b0, '0, 1'b0);
        step(1'b1, 10'h3EC, 1'b0); step(1'b0, '0, 1'b0); step(1'b0, '0, 1'b0);
        step(1'b1, 10'd30, 1'b0);
        check("neg_d3k1", 32'(DOUT3k1), 32'h3EC);

        step(1'b1, 10'd7, 1'b0);
        step(1'b0, '0, 1'b1);
        check("flush1_pad", 32'(PAD), 32'd1);
        step(1'b0, '0, 1'b1);
        check("flush_empty_vout", 32'(VOUT), 32'd0);

        step(1'b1, 10'd8, 1'b0); step(1'b1, 10'd9, 1'b0);
        step(1'b1, 10'd11, 1'b1);
        check("full_flush_pad", 32'(PAD), 32'd0);
        step(1'b1, 10'd12, 1'b1);
        check("vin_flush_d3k", 32'(DOUT3k), 32'd12);
        step(1'b1, 10'd13, 1'b0); step(1'b1, 10'd14, 1'b1);
        check("flush2_d3k2", 32'(DOUT3k2), 32'd0);

        step(1'b1, 10'd21, 1'b0); step(1'b1, 10'd22, 1'b0);
        @(negedge CLK);
        #2 RST_n = 1'b0;
        q.delete(); e0 = '0; e1 = '0; e2 = '0; ev = 1'b0; ep = 1'b0;
        #1 compare_all();
        @(negedge CLK);
        RST_n = 1'b1;
        step(1'b1, 10'd4, 1'b0); step(1'b1, 10'd5, 1'b0); step(1'b1, 10'd6, 1'b0);
        check("post_rst_d3k", 32'(DOUT3k), 32'd4);

        for (int sent = 0; sent < 3000;) begin
            logic v, f;
            v = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 19) == 0;
            step(v, NBIT'($urandom), f);
            if (v) sent++;
        end
        check("group_count", 32'(dut_groups), 32'(ref_groups));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
